core_inst_sequencer: RTL

- Hardware replacement for the bench-driven instruction stream of `core`. It produces the full 35-bit `inst` word every cycle.
- For each of the K*K kernel offsets it sequences these phases: weight fetch to L0, weight load into the PEs, activation fetch to L0, execute plus drain, and OFIFO drain to pmem.
- After all offsets it runs the output accumulation pass. Accumulation addresses are generated on chip from counters, so no address file is needed.
- Sits between the host or top-level control and `core`.

---
 rtl/core_inst_sequencer_if.sv | 24 ++
 rtl/core_inst_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host-side bus of core_inst_sequencer.
// With SEQ_PAUSE_EN defined, a pause input is added to the bus.
interface core_inst_sequencer_if;
  logic        start;
  logic        mode_select;
  logic [34:0] inst;
  logic        busy;
  logic        done;
  logic [2:0]  phase;
  logic [3:0]  kij;
  logic        acc_clr;
`ifdef SEQ_PAUSE_EN
  logic        pause;
  modport master (output start, mode_select, pause,
                  input  inst, busy, done, phase, kij, acc_clr);
  modport slave  (input  start, mode_select, pause,
                  output inst, busy, done, phase, kij, acc_clr);
`else
  modport master (output start, mode_select,
                  input  inst, busy, done, phase, kij, acc_clr);
  modport slave  (input  start, mode_select,
                  output inst, busy, done, phase, kij, acc_clr);
`endif
endinterface

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: generates the 35-bit core instruction word for a full
// conv pass (per kernel offset: weight fetch, weight load, activation fetch,
// execute+drain, OFIFO drain), then the on-chip addressed accumulation pass.
// Optional feature macro: SEQ_PAUSE_EN (adds a pause input that freezes the run).
//
// state    | meaning
// IDLE     | waiting for start, inst idle
// WL0      | weights xmem -> L0 (COL reads, l0_wr one cycle behind)
// WPE      | weights L0 -> PEs
// XL0      | activations xmem -> L0
// EXEC     | execute including array drain
// OFR      | OFIFO -> pmem write-back
// ACC      | output accumulation groups
// GAP_CYC  | idle cycles between phases, then continue to ret
module core_inst_sequencer #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int IN_W     = 6,
  parameter int K        = 3,
  parameter int ADDR_W   = 11,
  parameter int WGT_BASE = 1024,
  parameter int GAP      = 2
) (
  input logic clk,
  input logic reset,
  core_inst_sequencer_if.slave bus
);
  localparam int LEN_NIJ  = IN_W * IN_W;
  localparam int LEN_KIJ  = K * K;
  localparam int OUT_W    = IN_W - K + 1;
  localparam int LEN_EXEC = LEN_NIJ + ROW + COL;
  localparam int CW       = $clog2(LEN_EXEC + LEN_KIJ + GAP + COL + 2);
  localparam int KW       = $clog2(K + 1);
  localparam int OW       = $clog2(OUT_W + 1);
  localparam logic [34:0] INST_IDLE = 35'h1_800C_0000;

  if (LEN_KIJ * LEN_NIJ > 2 ** ADDR_W) begin : g_addr_chk
    $error("K*K*LEN_NIJ does not fit in ADDR_W address bits");
  end
  if (ADDR_W > 11) begin : g_field_chk
    $error("ADDR_W wider than the 11-bit inst address fields");
  end

  typedef enum logic [2:0] {IDLE, WL0, WPE, XL0, EXEC, OFR, ACC, GAP_CYC} state_t;

  state_t          state, state_n, ret, ret_n, tgt;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      kij, kij_n;
  logic [KW-1:0]   ki, ki_n, kj, kj_n;
  logic [OW-1:0]   orow, orow_n, ocol, ocol_n;
  logic            mode, mode_n, busy, busy_n, done, done_n;
  logic            acc_clr, acc_clr_n;
  logic [34:0]     inst, inst_n;
  logic [ADDR_W-1:0] a_x, a_p;
  logic            last, go, stall;

`ifdef SEQ_PAUSE_EN
  assign stall = bus.pause && (state != IDLE);
`else
  assign stall = 1'b0;
`endif

  // next-state sequencing, then decode of the next cycle's instruction word
  always_comb begin
    state_n = state; ret_n = ret; cnt_n = cnt; kij_n = kij;
    ki_n = ki; kj_n = kj; orow_n = orow; ocol_n = ocol;
    mode_n = mode; busy_n = busy; done_n = 1'b0;
    last = 1'b0; go = 1'b0; tgt = IDLE;
    if (!stall) begin
      case (state)
        IDLE: if (bus.start) begin
          state_n = WL0; cnt_n = '0; kij_n = '0;
          mode_n = bus.mode_select; busy_n = 1'b1;
        end
        WL0:  begin last = (cnt == CW'(COL));          tgt = WPE;  end
        WPE:  begin last = (cnt == CW'(COL - 1));      tgt = XL0;  end
        XL0:  begin last = (cnt == CW'(LEN_NIJ));      tgt = EXEC; end
        EXEC: begin last = (cnt == CW'(LEN_EXEC - 1)); tgt = OFR;  end
        OFR:  begin
          last = (cnt == CW'(LEN_NIJ - 1));
          tgt  = (kij == 4'(LEN_KIJ - 1)) ? ACC : WL0;
        end
        GAP_CYC: begin
          go  = (cnt == CW'(GAP - 1));
          tgt = ret;
          if (!go) cnt_n = cnt + CW'(1);
        end
        ACC: begin
          // k = ki*K+kj walks the kernel offsets during the read cycles
          if (cnt >= CW'(1) && cnt < CW'(LEN_KIJ)) begin
            if (kj == KW'(K - 1)) begin
              kj_n = '0;
              ki_n = ki + KW'(1);
            end else begin
              kj_n = kj + KW'(1);
            end
          end
          if (cnt == CW'(LEN_KIJ + 1)) begin
            cnt_n = '0; ki_n = '0; kj_n = '0;
            if (ocol == OW'(OUT_W - 1)) begin
              ocol_n = '0;
              if (orow == OW'(OUT_W - 1)) begin
                orow_n = '0; state_n = IDLE; busy_n = 1'b0; done_n = 1'b1;
              end else begin
                orow_n = orow + OW'(1);
              end
            end else begin
              ocol_n = ocol + OW'(1);
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: ;
      endcase

      if (state inside {WL0, WPE, XL0, EXEC, OFR}) begin
        if (!last) cnt_n = cnt + CW'(1);
        else if (GAP == 0) go = 1'b1;
        else begin
          state_n = GAP_CYC; cnt_n = '0; ret_n = tgt;
        end
      end

      if (go) begin
        state_n = tgt; cnt_n = '0;
        if (tgt == WL0) kij_n = kij + 4'd1;
        if (tgt == ACC) begin
          ki_n = '0; kj_n = '0; orow_n = '0; ocol_n = '0;
        end
      end
    end

    inst_n = INST_IDLE;
    inst_n[34] = mode_n;
    acc_clr_n = 1'b0;
    a_x = '0;
    a_p = '0;
    if (!stall) begin
      case (state_n)
        WL0: begin
          if (cnt_n < CW'(COL)) begin
            inst_n[19] = 1'b0;
            a_x = ADDR_W'(WGT_BASE) + ADDR_W'(kij_n) * ADDR_W'(COL) + ADDR_W'(cnt_n);
          end
          if (cnt_n != '0) inst_n[2] = 1'b1;
        end
        WPE: begin inst_n[3] = 1'b1; inst_n[0] = 1'b1; end
        XL0: begin
          if (cnt_n < CW'(LEN_NIJ)) begin
            inst_n[19] = 1'b0;
            a_x = ADDR_W'(cnt_n);
          end
          if (cnt_n != '0) inst_n[2] = 1'b1;
        end
        EXEC: begin inst_n[3] = 1'b1; inst_n[1] = 1'b1; end
        OFR: begin
          inst_n[6] = 1'b1; inst_n[32] = 1'b0; inst_n[31] = 1'b0;
          a_p = ADDR_W'(kij_n) * ADDR_W'(LEN_NIJ) + ADDR_W'(cnt_n);
        end
        ACC: begin
          if (cnt_n == '0) acc_clr_n = 1'b1;
          if (cnt_n >= CW'(1) && cnt_n <= CW'(LEN_KIJ)) begin
            inst_n[32] = 1'b0;
            a_p = ADDR_W'(ki_n) * ADDR_W'(K * LEN_NIJ) + ADDR_W'(kj_n) * ADDR_W'(LEN_NIJ)
                + (ADDR_W'(orow_n) + ADDR_W'(ki_n)) * ADDR_W'(IN_W)
                + ADDR_W'(ocol_n) + ADDR_W'(kj_n);
          end
          if (cnt_n >= CW'(2)) inst_n[33] = 1'b1;
        end
        default: ;
      endcase
    end
    inst_n[30:20] = 11'(a_p);
    inst_n[17:7]  = 11'(a_x);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE; ret <= IDLE; cnt <= '0; kij <= '0;
      ki <= '0; kj <= '0; orow <= '0; ocol <= '0;
      mode <= 1'b0; busy <= 1'b0; done <= 1'b0; acc_clr <= 1'b0;
      inst <= INST_IDLE;
    end else begin
      state <= state_n; ret <= ret_n; cnt <= cnt_n; kij <= kij_n;
      ki <= ki_n; kj <= kj_n; orow <= orow_n; ocol <= ocol_n;
      mode <= mode_n; busy <= busy_n; done <= done_n; acc_clr <= acc_clr_n;
      inst <= inst_n;
    end
  end

  assign bus.inst    = inst;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.phase   = 3'(state);
  assign bus.kij     = kij;
  assign bus.acc_clr = acc_clr;
endmodule
